// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep state codes, waveform codes and power-up
// parameter words used by the sweep controller and the input controller.
package dds_pkg;

   localparam logic [2:0] MANUAL = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] DWELL  = 3'd2;
   localparam logic [2:0] STEP   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [1:0] WAVE_SINE     = 2'b00;
   localparam logic [1:0] WAVE_SQUARE   = 2'b01;
   localparam logic [1:0] WAVE_TRIANGLE = 2'b10;
   localparam logic [1:0] WAVE_SAWTOOTH = 2'b11;

   localparam logic [15:0] FREQ_DEFAULT = 16'd10000;
   localparam logic [7:0]  AMP_DEFAULT  = 8'd30;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell interval counter: counts enabled clocks and flags the last clock of
// each interval of `limit` cycles.
module dds_dwell_timer #(
   parameter int DWELL_W = 24
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [DWELL_W-1:0] limit,
   output logic               tc
);

   logic [DWELL_W-1:0] count_reg;

   assign tc = enable && (count_reg == limit - DWELL_W'(1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= tc ? '0 : count_reg + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/dds_sweep_controller.sv
// Selects manual or swept DDS parameter words and commits them to the datapath
// only on a phase-accumulator wrap, so a waveform period is never cut short.
module dds_sweep_controller #(
   parameter int                FREQ_W       = 16,
   parameter int                AMP_W        = 8,
   parameter int                DWELL_W      = 24,
   parameter logic [FREQ_W-1:0] FREQ_DEFAULT = dds_pkg::FREQ_DEFAULT,
   parameter logic [AMP_W-1:0]  AMP_DEFAULT  = dds_pkg::AMP_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [FREQ_W-1:0]  man_freq_word,
   input  logic [AMP_W-1:0]   man_amp_word,
   input  logic [1:0]         man_waveform,
   input  logic               sweep_en,
   input  logic               sweep_loop,
   input  logic [FREQ_W-1:0]  sweep_start,
   input  logic [FREQ_W-1:0]  sweep_stop,
   input  logic [FREQ_W-1:0]  sweep_step,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic               phase_wrap,
   output logic [FREQ_W-1:0]  dds_freq_word,
   output logic [AMP_W-1:0]   dds_amp_word,
   output logic [1:0]         dds_waveform,
   output logic               cfg_update,
   output logic               sweep_active,
   output logic               sweep_done
);
   import dds_pkg::*;

   logic [2:0]         state_reg, state_next;
   logic [FREQ_W-1:0]  start_reg, stop_reg, step_reg, cur_freq_reg;
   logic [DWELL_W-1:0] dwell_reg;
   logic               dir_up_reg, loop_reg;
   logic [FREQ_W:0]    sum_ext, diff_ext;
   logic [FREQ_W-1:0]  step_freq, staged_freq;
   logic               at_stop, dwell_tc, active_next, done_next, commit;
   logic [FREQ_W-1:0]  dds_freq_reg;
   logic [AMP_W-1:0]   dds_amp_reg;
   logic [1:0]         dds_wave_reg;
   logic               cfg_update_reg, sweep_active_reg, sweep_done_reg;

   assign at_stop = (cur_freq_reg == stop_reg);

   dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (state_reg != DWELL),
      .enable (state_reg == DWELL),
      .limit  (dwell_reg),
      .tc     (dwell_tc)
   );

   always_ff @(posedge clock) begin
      if (reset) state_reg <= MANUAL;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MANUAL:  if (sweep_en) state_next = LOAD;
         LOAD:    state_next = DWELL;
         DWELL:   if (dwell_tc) state_next = STEP;
         STEP:    state_next = (at_stop && !loop_reg) ? DONE : DWELL;
         DONE:    state_next = DONE;
         default: state_next = MANUAL;
      endcase
      // Dropping sweep_en aborts from any sweep state, overriding a pending step.
      if (state_reg != MANUAL && !sweep_en) state_next = MANUAL;
   end

   always_comb begin
      staged_freq = (state_reg == MANUAL) ? man_freq_word : cur_freq_reg;
      active_next = (state_next == LOAD) || (state_next == DWELL) || (state_next == STEP);
      done_next   = (state_next == DONE);
      commit      = phase_wrap && ((staged_freq != dds_freq_reg) ||
                                   (man_amp_word != dds_amp_reg) ||
                                   (man_waveform != dds_wave_reg));
   end

   // One extra bit catches wrap-around so overshoot in either direction clamps to stop.
   always_comb begin
      sum_ext   = {1'b0, cur_freq_reg} + {1'b0, step_reg};
      diff_ext  = {1'b0, cur_freq_reg} - {1'b0, step_reg};
      step_freq = stop_reg;
      if (dir_up_reg) begin
         if (sum_ext <= {1'b0, stop_reg}) step_freq = sum_ext[FREQ_W-1:0];
      end else begin
         if (!diff_ext[FREQ_W] && (diff_ext[FREQ_W-1:0] >= stop_reg)) step_freq = diff_ext[FREQ_W-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         start_reg    <= '0;
         stop_reg     <= '0;
         step_reg     <= '0;
         dwell_reg    <= '0;
         dir_up_reg   <= 1'b0;
         loop_reg     <= 1'b0;
         cur_freq_reg <= '0;
      end else if (state_reg == LOAD) begin
         start_reg    <= sweep_start;
         stop_reg     <= sweep_stop;
         step_reg     <= (sweep_step == '0) ? FREQ_W'(1) : sweep_step;
         dwell_reg    <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
         dir_up_reg   <= (sweep_stop >= sweep_start);
         loop_reg     <= sweep_loop;
         cur_freq_reg <= sweep_start;
      end else if (state_reg == STEP && sweep_en) begin
         if (at_stop) begin
            if (loop_reg) cur_freq_reg <= start_reg;
         end else begin
            cur_freq_reg <= step_freq;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dds_freq_reg     <= FREQ_DEFAULT;
         dds_amp_reg      <= AMP_DEFAULT;
         dds_wave_reg     <= WAVE_SINE;
         cfg_update_reg   <= 1'b0;
         sweep_active_reg <= 1'b0;
         sweep_done_reg   <= 1'b0;
      end else begin
         if (commit) begin
            dds_freq_reg <= staged_freq;
            dds_amp_reg  <= man_amp_word;
            dds_wave_reg <= man_waveform;
         end
         cfg_update_reg   <= commit;
         sweep_active_reg <= active_next;
         sweep_done_reg   <= done_next;
      end
   end

   assign dds_freq_word = dds_freq_reg;
   assign dds_amp_word  = dds_amp_reg;
   assign dds_waveform  = dds_wave_reg;
   assign cfg_update    = cfg_update_reg;
   assign sweep_active  = sweep_active_reg;
   assign sweep_done    = sweep_done_reg;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: manual-mode vector table,
// directed sweeps and randomized sweeps against a list-based reference model.
module tb_dds_sweep_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] man_freq_word;
   logic [7:0]  man_amp_word;
   logic [1:0]  man_waveform;
   logic        sweep_en;
   logic        sweep_loop;
   logic [15:0] sweep_start;
   logic [15:0] sweep_stop;
   logic [15:0] sweep_step;
   logic [23:0] dwell_cycles;
   logic        phase_wrap;
   logic [15:0] dds_freq_word;
   logic [7:0]  dds_amp_word;
   logic [1:0]  dds_waveform;
   logic        cfg_update;
   logic        sweep_active;
   logic        sweep_done;

   dds_sweep_controller dut (
      .clock         (clock),
      .reset         (reset),
      .man_freq_word (man_freq_word),
      .man_amp_word  (man_amp_word),
      .man_waveform  (man_waveform),
      .sweep_en      (sweep_en),
      .sweep_loop    (sweep_loop),
      .sweep_start   (sweep_start),
      .sweep_stop    (sweep_stop),
      .sweep_step    (sweep_step),
      .dwell_cycles  (dwell_cycles),
      .phase_wrap    (phase_wrap),
      .dds_freq_word (dds_freq_word),
      .dds_amp_word  (dds_amp_word),
      .dds_waveform  (dds_waveform),
      .cfg_update    (cfg_update),
      .sweep_active  (sweep_active),
      .sweep_done    (sweep_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int mf, ma, mw, wrap;
      int ef, ea, ew, eu;
   } vec_t;

   int tests  = 0;
   int errors = 0;
   // Reference model: committed words and the sweep frequency left behind.
   int m_freq, m_amp, m_wave, m_cur;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic commit_model(input int wrap, input int sf, output int upd);
      upd = 0;
      if (wrap != 0 && (sf != m_freq || int'(man_amp_word) != m_amp || int'(man_waveform) != m_wave)) begin
         m_freq = sf;
         m_amp  = int'(man_amp_word);
         m_wave = int'(man_waveform);
         upd    = 1;
      end
   endtask

   task automatic check_all(input string tag, input int upd, input int act, input int done);
      chk({tag, " freq"}, int'(dds_freq_word), m_freq);
      chk({tag, " amp"},  int'(dds_amp_word),  m_amp);
      chk({tag, " wave"}, int'(dds_waveform),  m_wave);
      chk({tag, " upd"},  int'(cfg_update),    upd);
      chk({tag, " act"},  int'(sweep_active),  act);
      chk({tag, " done"}, int'(sweep_done),    done);
   endtask

   task automatic idle_cycles(input string tag, input int n, input int wrap);
      int upd;
      for (int i = 0; i < n; i++) begin
         sweep_en   = 1'b0;
         phase_wrap = (wrap != 0);
         commit_model(wrap, int'(man_freq_word), upd);
         tick();
         check_all(tag, upd, 0, 0);
      end
   endtask

   // Expected staged frequency comes from the list of values the sweep visits,
   // indexed by elapsed time: LOAD takes one cycle, then one value per dwell+1.
   task automatic run_sweep(input string tag, input int start, input int stop, input int step,
                            input int dwell, input int lp, input int wrap_period,
                            input int ncycles, input int scramble);
      int vals[$];
      int s, d, n, v, sf, upd, wrap, i, jn, act, done;
      bit en;
      s = (step == 0) ? 1 : step;
      d = (dwell == 0) ? 1 : dwell;
      v = start;
      vals.push_back(v);
      while (v != stop) begin
         if (stop >= start) v = (v + s > stop) ? stop : v + s;
         else               v = (v - s < stop) ? stop : v - s;
         vals.push_back(v);
      end
      n = vals.size();
      sweep_start  = 16'(start);
      sweep_stop   = 16'(stop);
      sweep_step   = 16'(step);
      dwell_cycles = 24'(dwell);
      sweep_loop   = (lp != 0);
      for (int k = 0; k <= ncycles; k++) begin
         en   = (k < ncycles);
         wrap = (wrap_period <= 1) ? 1 : (((k % wrap_period) == wrap_period - 1) ? 1 : 0);
         sweep_en   = en;
         phase_wrap = (wrap != 0);
         if (scramble != 0 && k >= 2) begin
            sweep_start  = 16'($urandom);
            sweep_stop   = 16'($urandom);
            sweep_step   = 16'($urandom);
            dwell_cycles = 24'($urandom_range(0, 3));
            sweep_loop   = 1'($urandom);
         end
         if (k == 0)      sf = int'(man_freq_word);
         else if (k == 1) sf = m_cur;
         else begin
            i  = (k - 2) / (d + 1);
            sf = (lp != 0) ? vals[i % n] : vals[(i >= n) ? n - 1 : i];
         end
         commit_model(wrap, sf, upd);
         tick();
         if (!en) begin
            act = 0; done = 0;
         end else if (k + 1 == 1) begin
            act = 1; done = 0;
         end else begin
            jn   = k + 1 - 2;
            done = (lp == 0 && jn >= n * (d + 1)) ? 1 : 0;
            act  = 1 - done;
         end
         check_all(tag, upd, act, done);
         if (k == ncycles) m_cur = sf;
      end
      sweep_en = 1'b0;
   endtask

   initial begin
      vec_t tbl[10];
      int   any_upd, any_chg, start, stop, delta;

      tbl[0] = '{12000,  30, 0, 0, 10000,  30, 0, 0};
      tbl[1] = '{12000,  30, 0, 0, 10000,  30, 0, 0};
      tbl[2] = '{12000,  30, 0, 1, 12000,  30, 0, 1};
      tbl[3] = '{12000,  30, 0, 1, 12000,  30, 0, 0};
      tbl[4] = '{12000,  99, 2, 0, 12000,  30, 0, 0};
      tbl[5] = '{12000,  99, 2, 1, 12000,  99, 2, 1};
      tbl[6] = '{  500,  99, 3, 1,   500,  99, 3, 1};
      tbl[7] = '{  500,  99, 3, 1,   500,  99, 3, 0};
      tbl[8] = '{65535, 255, 1, 0,   500,  99, 3, 0};
      tbl[9] = '{65535, 255, 1, 1, 65535, 255, 1, 1};

      reset = 1'b1; sweep_en = 1'b0; phase_wrap = 1'b0; sweep_loop = 1'b0;
      man_freq_word = 16'd12000; man_amp_word = 8'd30; man_waveform = 2'd0;
      sweep_start = '0; sweep_stop = '0; sweep_step = '0; dwell_cycles = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("reset freq", int'(dds_freq_word), 10000);
      chk("reset amp",  int'(dds_amp_word), 30);
      chk("reset wave", int'(dds_waveform), 0);
      chk("reset upd",  int'(cfg_update), 0);
      chk("reset act",  int'(sweep_active), 0);
      chk("reset done", int'(sweep_done), 0);

      any_upd = 0; any_chg = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (cfg_update) any_upd = 1;
         if (dds_freq_word != 16'd10000) any_chg = 1;
      end
      chk("nowrap upd seen", any_upd, 0);
      chk("nowrap freq changed", any_chg, 0);

      for (int i = 0; i < 10; i++) begin
         man_freq_word = 16'(tbl[i].mf);
         man_amp_word  = 8'(tbl[i].ma);
         man_waveform  = 2'(tbl[i].mw);
         phase_wrap    = (tbl[i].wrap != 0);
         tick();
         chk($sformatf("vec%0d freq", i), int'(dds_freq_word), tbl[i].ef);
         chk($sformatf("vec%0d amp", i),  int'(dds_amp_word),  tbl[i].ea);
         chk($sformatf("vec%0d wave", i), int'(dds_waveform),  tbl[i].ew);
         chk($sformatf("vec%0d upd", i),  int'(cfg_update),    tbl[i].eu);
      end
      m_freq = 65535; m_amp = 255; m_wave = 1; m_cur = 0;

      man_freq_word = 16'd7000; man_amp_word = 8'd30; man_waveform = 2'd0;
      run_sweep("up1", 1000, 1250, 100, 4, 0, 1, 30, 0);
      chk("up1 end freq", int'(dds_freq_word), 1250);
      man_freq_word = 16'd4321;
      idle_cycles("man1", 3, 1);
      chk("man1 freq", int'(dds_freq_word), 4321);

      run_sweep("loopdn", 3000, 2800, 150, 3, 1, 1, 40, 1);
      run_sweep("degen", 100, 110, 0, 0, 0, 1, 30, 0);
      run_sweep("top", 65535, 65535, 7, 2, 0, 1, 12, 0);
      run_sweep("ovf", 65000, 65535, 60000, 1, 0, 1, 10, 0);
      run_sweep("udf", 100, 0, 300, 1, 1, 1, 12, 0);

      sweep_start = 16'd500; sweep_stop = 16'd900; sweep_step = 16'd100;
      dwell_cycles = 24'd10; sweep_loop = 1'b0;
      sweep_en = 1'b1; phase_wrap = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("abort active before", int'(sweep_active), 1);
      reset = 1'b1; sweep_en = 1'b0;
      tick();
      reset = 1'b0;
      chk("abort freq", int'(dds_freq_word), 10000);
      chk("abort amp",  int'(dds_amp_word), 30);
      chk("abort wave", int'(dds_waveform), 0);
      chk("abort upd",  int'(cfg_update), 0);
      chk("abort act",  int'(sweep_active), 0);
      chk("abort done", int'(sweep_done), 0);
      m_freq = 10000; m_amp = 30; m_wave = 0; m_cur = 0;
      phase_wrap = 1'b0;

      run_sweep("sparse", 1000, 2000, 50, 4, 0, 20, 100, 0);

      for (int r = 0; r < 12; r++) begin
         start = int'($urandom_range(0, 65535));
         delta = int'($urandom_range(0, 3000));
         if ($urandom_range(0, 1) == 1) stop = (start + delta > 65535) ? 65535 : start + delta;
         else                           stop = (start - delta < 0) ? 0 : start - delta;
         man_freq_word = 16'($urandom);
         man_amp_word  = 8'($urandom);
         man_waveform  = 2'($urandom);
         run_sweep($sformatf("rnd%0d", r), start, stop, int'($urandom_range(0, 700)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 1)),
                   int'($urandom_range(1, 7)), int'($urandom_range(4, 80)), 1);
         idle_cycles($sformatf("rndman%0d", r), 2, int'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
